// File: rtl/core_ctrl.sv
// core_ctrl: instruction sequencer for one weight-stationary convolution run.
// Emits a 36-bit core instruction word every cycle; all outputs are registered.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | NOP, waiting for start
// W_LOAD     | read col weight vectors from xmem into L0 (col+1 cycles)
// W_KERN     | shift weights from L0 into the PE array (col cycles)
// W_GAP      | NOP while weights settle (row+col cycles)
// A_LOAD     | read len_nij activation vectors into L0 (len_nij+1 cycles)
// EXEC       | stream activations through the array (len_nij cycles)
// EXEC_GAP   | NOP while the array flushes (row+col cycles)
// DRAIN_WAIT | NOP until the OFIFO holds a complete row
// DRAIN_RD   | read old psum for accumulation (kij > 0 only)
// DRAIN_WR   | pop OFIFO and write/accumulate psum
// NEXT       | advance kij or finish
// DONE       | one-cycle done pulse
module core_ctrl #(
  parameter int          ROW       = 8,
  parameter int          COL       = 8,
  parameter int          LEN_NIJ   = 36,
  parameter int          LEN_KIJ   = 9,
  parameter logic [10:0] ACT_BASE  = 11'd0,
  parameter logic [10:0] W_BASE    = 11'd64,
  parameter logic [10:0] PSUM_BASE = 11'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [35:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij
);

  localparam int CW = 16;

  // Down-counter load values: the phase ends when the counter reaches zero.
  localparam logic [CW-1:0] CNT_W_LOAD = CW'(COL);
  localparam logic [CW-1:0] CNT_W_KERN = CW'(COL - 1);
  localparam logic [CW-1:0] CNT_GAP    = CW'(ROW + COL - 1);
  localparam logic [CW-1:0] CNT_A_LOAD = CW'(LEN_NIJ);
  localparam logic [CW-1:0] CNT_EXEC   = CW'(LEN_NIJ - 1);
  localparam logic [CW-1:0] O_LAST     = CW'(LEN_NIJ - 1);
  localparam logic [3:0]    KIJ_LAST   = 4'(LEN_KIJ - 1);

  localparam logic [35:0] NOP = 36'h1_800C_0000;

  localparam int B_OEN  = 35;
  localparam int B_ACC  = 33;
  localparam int B_CENP = 32;
  localparam int B_WENP = 31;
  localparam int B_CENX = 19;
  localparam int B_OFRD = 6;
  localparam int B_L0RD = 3;
  localparam int B_L0WR = 2;
  localparam int B_EXEC = 1;
  localparam int B_LOAD = 0;

  typedef enum logic [3:0] {
    IDLE, W_LOAD, W_KERN, W_GAP, A_LOAD, EXEC, EXEC_GAP,
    DRAIN_WAIT, DRAIN_RD, DRAIN_WR, NEXT, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  o_q, o_d;
  logic [3:0]     kij_q, kij_d;
  logic [35:0]    inst_q, inst_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [10:0]    w_addr, a_addr, p_addr;

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_q     <= '0;
      kij_q   <= '0;
      inst_q  <= NOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      kij_q   <= kij_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic, then output decode from the next-state values so the
  // registered inst word lines up with the state it describes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    kij_d   = kij_q;
    inst_d  = NOP;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = W_LOAD;
          cnt_d   = CNT_W_LOAD;
          kij_d   = 4'd0;
        end
      end
      W_LOAD: begin
        if (cnt_q == '0) begin
          state_d = W_KERN;
          cnt_d   = CNT_W_KERN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      W_KERN: begin
        if (cnt_q == '0) begin
          state_d = W_GAP;
          cnt_d   = CNT_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      W_GAP: begin
        if (cnt_q == '0) begin
          state_d = A_LOAD;
          cnt_d   = CNT_A_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      A_LOAD: begin
        if (cnt_q == '0) begin
          state_d = EXEC;
          cnt_d   = CNT_EXEC;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = EXEC_GAP;
          cnt_d   = CNT_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      EXEC_GAP: begin
        if (cnt_q == '0) begin
          state_d = DRAIN_WAIT;
          o_d     = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRAIN_WAIT: begin
        if (ofifo_valid) begin
          state_d = (kij_q == 4'd0) ? DRAIN_WR : DRAIN_RD;
        end
      end
      DRAIN_RD: begin
        state_d = DRAIN_WR;
      end
      DRAIN_WR: begin
        if (o_q == O_LAST) begin
          state_d = NEXT;
        end else begin
          o_d     = o_q + 1'b1;
          state_d = DRAIN_WAIT;
        end
      end
      NEXT: begin
        if (kij_q == KIJ_LAST) begin
          state_d = DONE;
        end else begin
          kij_d   = kij_q + 1'b1;
          state_d = W_LOAD;
          cnt_d   = CNT_W_LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Counter runs down, so the cycle index within a load phase is (len - cnt).
    w_addr = W_BASE + 11'(int'(kij_d) * COL) + 11'(COL) - 11'(cnt_d);
    a_addr = ACT_BASE + 11'(LEN_NIJ) - 11'(cnt_d);
    p_addr = PSUM_BASE + 11'(o_d);

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);

    unique case (state_d)
      W_LOAD: begin
        if (cnt_d != '0) begin
          inst_d[B_CENX] = 1'b0;
          inst_d[17:7]   = w_addr;
        end
        inst_d[B_L0WR] = (cnt_d != CNT_W_LOAD);
      end
      W_KERN: begin
        inst_d[B_LOAD] = 1'b1;
        inst_d[B_L0RD] = 1'b1;
      end
      A_LOAD: begin
        if (cnt_d != '0) begin
          inst_d[B_CENX] = 1'b0;
          inst_d[17:7]   = a_addr;
        end
        inst_d[B_L0WR] = (cnt_d != CNT_A_LOAD);
      end
      EXEC: begin
        inst_d[B_EXEC] = 1'b1;
        inst_d[B_L0RD] = 1'b1;
      end
      DRAIN_RD: begin
        inst_d[B_CENP] = 1'b0;
        inst_d[30:20]  = p_addr;
      end
      DRAIN_WR: begin
        inst_d[B_OEN]  = 1'b1;
        inst_d[B_OFRD] = 1'b1;
        inst_d[B_CENP] = 1'b0;
        inst_d[B_WENP] = 1'b0;
        inst_d[30:20]  = p_addr;
        inst_d[B_ACC]  = (kij_d != 4'd0);
      end
      default: begin
        inst_d = NOP;
      end
    endcase
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign kij  = kij_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: scoreboard bench for core_ctrl with a reduced run size.
module tb_core_ctrl;

  localparam int ROW  = 8;
  localparam int COL  = 8;
  localparam int NIJ  = 4;
  localparam int NKIJ = 2;
  localparam logic [35:0] NOP = 36'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
  logic [35:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij;

  always #5 clk = ~clk;

  core_ctrl #(
    .ROW(ROW), .COL(COL), .LEN_NIJ(NIJ), .LEN_KIJ(NKIJ),
    .ACT_BASE(11'd0), .W_BASE(11'd64), .PSUM_BASE(11'd0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .kij(kij)
  );

  typedef struct {
    logic [35:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij;
    logic        valid;
    logic        start;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Pack an instruction word from the field list.
  function automatic logic [35:0] mk(input bit oen, input bit acc, input bit cenp, input bit wenp,
                                     input logic [10:0] paddr, input bit cenx,
                                     input logic [10:0] xaddr, input bit ofrd, input bit l0rd,
                                     input bit l0wr, input bit ex, input bit ld);
    logic [35:0] w;
    w = '0;
    w[35] = oen; w[33] = acc; w[32] = cenp; w[31] = wenp; w[30:20] = paddr;
    w[19] = cenx; w[18] = 1'b1; w[17:7] = xaddr; w[6] = ofrd;
    w[3] = l0rd; w[2] = l0wr; w[1] = ex; w[0] = ld;
    return w;
  endfunction

  task automatic push(input logic [35:0] i, input bit b, input bit d, input int k, input bit v);
    exp_t e;
    e.inst = i; e.busy = b; e.done = d; e.kij = 4'(k); e.valid = v; e.start = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_nops(input int n, input int k);
    for (int i = 0; i < n; i++) push(NOP, 1, 0, k, 1);
  endtask

  // Expected cycle-by-cycle stream for one run; one drain entry may stall.
  task automatic build_run(input int stall_k, input int stall_o, input int stall_n);
    for (int k = 0; k < NKIJ; k++) begin
      for (int i = 0; i <= COL; i++)
        push(mk(0, 0, 1, 1, 11'd0, (i == COL), (i < COL) ? 11'(64 + k * COL + i) : 11'd0,
                0, 0, (i > 0), 0, 0), 1, 0, k, 1);
      for (int i = 0; i < COL; i++)
        push(mk(0, 0, 1, 1, 11'd0, 1, 11'd0, 0, 1, 0, 0, 1), 1, 0, k, 1);
      push_nops(ROW + COL, k);
      for (int i = 0; i <= NIJ; i++)
        push(mk(0, 0, 1, 1, 11'd0, (i == NIJ), (i < NIJ) ? 11'(i) : 11'd0,
                0, 0, (i > 0), 0, 0), 1, 0, k, 1);
      for (int i = 0; i < NIJ; i++)
        push(mk(0, 0, 1, 1, 11'd0, 1, 11'd0, 0, 1, 0, 1, 0), 1, 0, k, 1);
      push_nops(ROW + COL, k);
      for (int o = 0; o < NIJ; o++) begin
        if (k == stall_k && o == stall_o)
          for (int s = 0; s < stall_n; s++) push(NOP, 1, 0, k, 0);
        push(NOP, 1, 0, k, 1);
        if (k > 0) push(mk(0, 0, 0, 1, 11'(o), 1, 11'd0, 0, 0, 0, 0, 0), 1, 0, k, 1);
        push(mk(1, (k != 0), 0, 0, 11'(o), 1, 11'd0, 1, 0, 0, 0, 0), 1, 0, k, 1);
      end
      push(NOP, 1, 0, k, 1);
    end
    push(NOP, 0, 1, NKIJ - 1, 1);
  endtask

  task automatic mark_start(input int idx);
    exp_t e;
    e = sb[idx];
    e.start = 1'b1;
    sb[idx] = e;
  endtask

  task automatic kick();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Pop and compare one entry per cycle; optionally reset at entry abort_at.
  task automatic consume(input int abort_at);
    exp_t e;
    int idx;
    idx = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val($sformatf("inst@%0d", idx), 64'(inst), 64'(e.inst));
      check_val($sformatf("busy@%0d", idx), 64'(busy), 64'(e.busy));
      check_val($sformatf("done@%0d", idx), 64'(done), 64'(e.done));
      check_val($sformatf("kij@%0d", idx), 64'(kij), 64'(e.kij));
      ofifo_valid = e.valid;
      start = e.start;
      if (idx == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        sb.delete();
        check_val("abort_inst", 64'(inst), 64'(NOP));
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_kij", 64'(kij), 64'd0);
        return;
      end
      @(posedge clk); #1;
      idx++;
    end
    start = 1'b0;
    ofifo_valid = 1'b1;
  endtask

  task automatic check_idle(input int n, input bit chk_kij);
    for (int i = 0; i < n; i++) begin
      check_val("idle_inst", 64'(inst), 64'(NOP));
      check_val("idle_busy", 64'(busy), 64'd0);
      check_val("idle_done", 64'(done), 64'd0);
      if (chk_kij) check_val("idle_kij", 64'(kij), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle(5, 1'b1);

    // Plain run; start pulsed inside EXEC of kij=0 and in the DONE cycle.
    build_run(-1, -1, 0);
    mark_start(40);
    mark_start(sb.size() - 1);
    kick();
    consume(-1);
    check_idle(3, 1'b0);

    // Drain stall: ofifo_valid low for 20 cycles at kij=1, entry 1.
    build_run(1, 1, 20);
    kick();
    consume(-1);
    check_idle(2, 1'b0);

    // Reset during A_LOAD of kij=0, then a clean restart.
    build_run(-1, -1, 0);
    kick();
    consume(35);
    check_idle(2, 1'b1);
    build_run(-1, -1, 0);
    kick();
    consume(-1);
    check_idle(2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
